// File: rtl/fetch_pkg.sv
// Shared types and next-PC select encodings for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SQUASH = 2'b01,
    STALL  = 2'b10,
    HALT   = 2'b11
  } fetch_state_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_REL  = 2'b01;
  localparam logic [1:0] PCSEL_REG  = 2'b10;
  localparam logic [1:0] PCSEL_ZERO = 2'b11;

endpackage

// File: rtl/satCounter.sv
// Event counter that sticks at all-ones instead of wrapping.
module satCounter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Next-PC source selection, stall/flush control and halt sequencing for the fetch stage.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             condBranch,
  input  logic             condTrue,
  input  logic             uncondBranch,
  input  logic             regBranch,
  input  logic             halt,
  input  logic             restart,
  output logic [1:0]       brTaken,
  output logic             uncondBr,
  output logic             pcEnable,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             halted,
  output logic [CNT_W-1:0] takenCount,
  output logic [CNT_W-1:0] stallCount
);

  fetch_state_t state_q, state_d;
  logic         taken_inc, stall_inc;
  logic         redirect;

  assign redirect = regBranch | uncondBranch | (condBranch & condTrue);

  always_comb begin
    brTaken   = PCSEL_SEQ;
    uncondBr  = 1'b0;
    pcEnable  = 1'b1;
    ifidWrite = 1'b1;
    ifidFlush = 1'b0;
    taken_inc = 1'b0;
    stall_inc = 1'b0;
    state_d   = state_q;

    if (restart) begin
      brTaken   = PCSEL_ZERO;
      ifidFlush = 1'b1;
      state_d   = SQUASH;
    end else begin
      unique case (state_q)
        HALT: begin
          pcEnable  = 1'b0;
          ifidWrite = 1'b0;
        end
        // Decode slot is a bubble: its decode inputs are stale and ignored.
        SQUASH: state_d = RUN;
        RUN, STALL: begin
          if (halt) begin
            pcEnable  = 1'b0;
            ifidFlush = 1'b1;
            state_d   = HALT;
          end else if (stall) begin
            pcEnable  = 1'b0;
            ifidWrite = 1'b0;
            stall_inc = 1'b1;
            state_d   = STALL;
          end else if (redirect) begin
            brTaken   = regBranch ? PCSEL_REG : PCSEL_REL;
            uncondBr  = ~regBranch & uncondBranch;
            ifidFlush = 1'b1;
            taken_inc = 1'b1;
            state_d   = SQUASH;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted = (state_q == HALT);

  satCounter #(.WIDTH(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (taken_inc),
    .count (takenCount)
  );

  satCounter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stallCount)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with 4-bit counters.
module tb_fetch_controller;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall, condBranch, condTrue, uncondBranch, regBranch, halt, restart;
  logic [1:0]       brTaken;
  logic             uncondBr, pcEnable, ifidWrite, ifidFlush, halted;
  logic [CNT_W-1:0] takenCount, stallCount;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_controller #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .condBranch   (condBranch),
    .condTrue     (condTrue),
    .uncondBranch (uncondBranch),
    .regBranch    (regBranch),
    .halt         (halt),
    .restart      (restart),
    .brTaken      (brTaken),
    .uncondBr     (uncondBr),
    .pcEnable     (pcEnable),
    .ifidWrite    (ifidWrite),
    .ifidFlush    (ifidFlush),
    .halted       (halted),
    .takenCount   (takenCount),
    .stallCount   (stallCount)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stall = 0; condBranch = 0; condTrue = 0; uncondBranch = 0;
    regBranch = 0; halt = 0; restart = 0;
  endtask

  // Advance one edge and settle 1ns past it; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    repeat (3) tick();
    n_checks++; if (brTaken !== 2'b00) begin n_fail++; $display("FAIL rst_brTaken got %b exp 00", brTaken); end
    n_checks++; if (pcEnable !== 1'b1) begin n_fail++; $display("FAIL rst_pcEnable got %b exp 1", pcEnable); end
    n_checks++; if (ifidWrite !== 1'b1 || ifidFlush !== 1'b0 || uncondBr !== 1'b0) begin
      n_fail++; $display("FAIL rst_ctl got w%b f%b u%b exp w1 f0 u0", ifidWrite, ifidFlush, uncondBr); end
    n_checks++; if (takenCount !== 4'd0 || stallCount !== 4'd0) begin
      n_fail++; $display("FAIL rst_counts got %0d/%0d exp 0/0", takenCount, stallCount); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b exp 0", halted); end
    reset = 1;
    tick();
    n_checks++; if (brTaken !== 2'b00 || pcEnable !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_seq got br%b pe%b exp br00 pe1", brTaken, pcEnable); end
  endtask

  task automatic test_branches();
    condBranch = 1; condTrue = 1; #1;
    n_checks++; if (brTaken !== 2'b01 || uncondBr !== 1'b0 || ifidFlush !== 1'b1 || pcEnable !== 1'b1) begin
      n_fail++; $display("FAIL cond_taken got br%b u%b f%b pe%b exp br01 u0 f1 pe1", brTaken, uncondBr, ifidFlush, pcEnable); end
    tick();
    n_checks++; if (takenCount !== 4'd1) begin n_fail++; $display("FAIL cond_count got %0d exp 1", takenCount); end
    #1;  // condBranch still held in the SQUASH cycle
    n_checks++; if (brTaken !== 2'b00 || ifidFlush !== 1'b0) begin
      n_fail++; $display("FAIL squash_ignore got br%b f%b exp br00 f0", brTaken, ifidFlush); end
    tick();
    n_checks++; if (takenCount !== 4'd1) begin n_fail++; $display("FAIL squash_count got %0d exp 1", takenCount); end
    condTrue = 0; #1;
    n_checks++; if (brTaken !== 2'b00 || ifidFlush !== 1'b0) begin
      n_fail++; $display("FAIL cond_false got br%b f%b exp br00 f0", brTaken, ifidFlush); end
    tick();
    n_checks++; if (takenCount !== 4'd1) begin n_fail++; $display("FAIL cond_false_count got %0d exp 1", takenCount); end
    idle_inputs(); regBranch = 1; #1;
    n_checks++; if (brTaken !== 2'b10 || uncondBr !== 1'b0 || ifidFlush !== 1'b1) begin
      n_fail++; $display("FAIL reg_branch got br%b u%b f%b exp br10 u0 f1", brTaken, uncondBr, ifidFlush); end
    tick();
    idle_inputs(); tick();
    n_checks++; if (takenCount !== 4'd2) begin n_fail++; $display("FAIL reg_count got %0d exp 2", takenCount); end
    uncondBranch = 1; #1;
    n_checks++; if (brTaken !== 2'b01 || uncondBr !== 1'b1 || ifidFlush !== 1'b1) begin
      n_fail++; $display("FAIL uncond got br%b u%b f%b exp br01 u1 f1", brTaken, uncondBr, ifidFlush); end
    tick();
    idle_inputs(); tick();
    n_checks++; if (takenCount !== 4'd3) begin n_fail++; $display("FAIL uncond_count got %0d exp 3", takenCount); end
  endtask

  task automatic test_stall();
    stall = 1; uncondBranch = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (pcEnable !== 1'b0 || ifidWrite !== 1'b0 || brTaken !== 2'b00) begin
        n_fail++; $display("FAIL stall_hold[%0d] got pe%b w%b br%b exp pe0 w0 br00", i, pcEnable, ifidWrite, brTaken); end
      tick();
    end
    n_checks++; if (stallCount !== 4'd3 || takenCount !== 4'd3) begin
      n_fail++; $display("FAIL stall_counts got s%0d t%0d exp s3 t3", stallCount, takenCount); end
    stall = 0; #1;
    n_checks++; if (brTaken !== 2'b01 || uncondBr !== 1'b1 || pcEnable !== 1'b1) begin
      n_fail++; $display("FAIL stall_release got br%b u%b pe%b exp br01 u1 pe1", brTaken, uncondBr, pcEnable); end
    tick();
    n_checks++; if (takenCount !== 4'd4) begin n_fail++; $display("FAIL stall_release_count got %0d exp 4", takenCount); end
    idle_inputs(); tick();
  endtask

  task automatic test_halt_restart();
    halt = 1; #1;
    n_checks++; if (pcEnable !== 1'b0 || ifidFlush !== 1'b1) begin
      n_fail++; $display("FAIL halt_enter got pe%b f%b exp pe0 f1", pcEnable, ifidFlush); end
    tick();
    halt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (halted !== 1'b1 || pcEnable !== 1'b0 || ifidWrite !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold[%0d] got h%b pe%b w%b exp h1 pe0 w0", i, halted, pcEnable, ifidWrite); end
      tick();
    end
    restart = 1; #1;
    n_checks++; if (brTaken !== 2'b11 || ifidFlush !== 1'b1 || pcEnable !== 1'b1) begin
      n_fail++; $display("FAIL restart got br%b f%b pe%b exp br11 f1 pe1", brTaken, ifidFlush, pcEnable); end
    tick();
    restart = 0; #1;
    n_checks++; if (halted !== 1'b0 || brTaken !== 2'b00 || ifidFlush !== 1'b0) begin
      n_fail++; $display("FAIL restart_squash got h%b br%b f%b exp h0 br00 f0", halted, brTaken, ifidFlush); end
    tick();
    halt = 1; restart = 1; #1;
    n_checks++; if (brTaken !== 2'b11 || pcEnable !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart got br%b pe%b exp br11 pe1", brTaken, pcEnable); end
    tick();
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_restart_state got h%b exp 0", halted); end
    idle_inputs(); tick();
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 3;
    stall = 1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (exp_cnt < 15) exp_cnt++;
      n_checks++; if (stallCount !== exp_cnt[CNT_W-1:0]) begin
        n_fail++; $display("FAIL stall_sat[%0d] got %0d exp %0d", i, stallCount, exp_cnt); end
    end
    #2;
    stall = 0; reset = 0; #1;
    n_checks++; if (stallCount !== 4'd0 || takenCount !== 4'd0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got s%0d t%0d h%b exp 0 0 0", stallCount, takenCount, halted); end
    n_checks++; if (pcEnable !== 1'b1 || ifidWrite !== 1'b1 || brTaken !== 2'b00) begin
      n_fail++; $display("FAIL async_rst_ctl got pe%b w%b br%b exp pe1 w1 br00", pcEnable, ifidWrite, brTaken); end
    tick();
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_branches();
    test_stall();
    test_halt_restart();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
